// File: rtl/predecode_pkg.sv
// Shared opcode constants and predecode encodings for the predecode queue.
package predecode_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_R_TYPE = 5'b01100;
  localparam logic [4:0] OPC_I_TYPE = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam logic [4:0] OPC_AMO    = 5'b01011;

  typedef enum logic [1:0] {
    BJ_OTHER  = 2'b00,
    BJ_JUMP   = 2'b01,
    BJ_BRANCH = 2'b10
  } bj_op_e;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'b000,
    IMM_J     = 3'b001,
    IMM_S     = 3'b010,
    IMM_B     = 3'b011,
    IMM_I     = 3'b100,
    IMM_I_ALU = 3'b101
  } imm_src_e;

endpackage

// File: rtl/predecode_lut.sv
// Combinational opcode table: maps instruction opcode bits to branch/jump class,
// immediate format and an illegal flag.
module predecode_lut
  import predecode_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] low_bits,
  output logic [1:0] bj_op,
  output logic [2:0] imm_src,
  output logic       illegal
);

  always_comb begin
    bj_op   = BJ_OTHER;
    imm_src = IMM_NONE;
    illegal = 1'b0;
    if (low_bits != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LOAD:   imm_src = IMM_I;
        OPC_STORE:  imm_src = IMM_S;
        OPC_R_TYPE: imm_src = IMM_NONE;
        OPC_I_TYPE: imm_src = IMM_I_ALU;
        OPC_BRANCH: begin bj_op = BJ_BRANCH; imm_src = IMM_B; end
        OPC_JAL:    begin bj_op = BJ_JUMP;   imm_src = IMM_J; end
        OPC_JALR:   begin bj_op = BJ_JUMP;   imm_src = IMM_I; end
        OPC_LUI:    imm_src = IMM_NONE;
        OPC_AUIPC:  imm_src = IMM_NONE;
        OPC_SYSTEM: imm_src = IMM_I_ALU;
        OPC_AMO:    imm_src = IMM_NONE;
        default:    illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/predecode_queue.sv
// Fetch-to-decode FIFO that predecodes each instruction once at push time.
// Define PREDECODE_TARGET_EN to add a stored branch/jump target per entry (out_target_o).
module predecode_queue
  import predecode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_instr_i,
  input  logic [XLEN-1:0]          in_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_instr_o,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [1:0]               out_branch_jump_op_o,
  output logic [2:0]               out_imm_src_o,
  output logic                     out_illegal_o,
`ifdef PREDECODE_TARGET_EN
  output logic [XLEN-1:0]          out_target_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     instr_q   [DEPTH];
  logic [XLEN-1:0] pc_q      [DEPTH];
  logic [1:0]      bj_q      [DEPTH];
  logic [2:0]      imm_q     [DEPTH];
  logic            illegal_q [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          push, pop;

  logic [1:0] lut_bj;
  logic [2:0] lut_imm;
  logic       lut_illegal;

  predecode_lut u_lut (
    .opcode   (in_instr_i[6:2]),
    .low_bits (in_instr_i[1:0]),
    .bj_op    (lut_bj),
    .imm_src  (lut_imm),
    .illegal  (lut_illegal)
  );

  assign in_ready_o  = (count_q < CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload is cleared on reset so the head fields are never unknown.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]   <= '0;
        pc_q[i]      <= '0;
        bj_q[i]      <= '0;
        imm_q[i]     <= '0;
        illegal_q[i] <= 1'b0;
      end
    end else if (push && !flush_i) begin
      instr_q[wr_ptr]   <= in_instr_i;
      pc_q[wr_ptr]      <= in_pc_i;
      bj_q[wr_ptr]      <= lut_bj;
      imm_q[wr_ptr]     <= lut_imm;
      illegal_q[wr_ptr] <= lut_illegal;
    end
  end

  assign out_instr_o          = instr_q[rd_ptr];
  assign out_pc_o             = pc_q[rd_ptr];
  assign out_branch_jump_op_o = bj_q[rd_ptr];
  assign out_imm_src_o        = imm_q[rd_ptr];
  assign out_illegal_o        = illegal_q[rd_ptr];

`ifdef PREDECODE_TARGET_EN
  logic [XLEN-1:0] target_q [DEPTH];
  logic [12:0]     b_imm;
  logic [20:0]     j_imm;
  logic [XLEN-1:0] in_target;

  always_comb begin
    b_imm = {in_instr_i[31], in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8], 1'b0};
    j_imm = {in_instr_i[31], in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21], 1'b0};
    in_target = in_pc_i + XLEN'(4);
    if (lut_bj == BJ_BRANCH)
      in_target = in_pc_i + {{(XLEN-13){b_imm[12]}}, b_imm};
    else if (lut_bj == BJ_JUMP && lut_imm == IMM_J)
      in_target = in_pc_i + {{(XLEN-21){j_imm[20]}}, j_imm};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) target_q[i] <= '0;
    end else if (push && !flush_i) begin
      target_q[wr_ptr] <= in_target;
    end
  end

  assign out_target_o = target_q[rd_ptr];
`endif

endmodule

// File: tb/tb_predecode_queue.sv
// Self-checking bench for predecode_queue: queue-based reference model plus literal spot checks.
module tb_predecode_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  out_op;
  logic [2:0]  out_imm;
  logic        out_ill;
  logic [2:0]  count;
`ifdef PREDECODE_TARGET_EN
  logic [31:0] out_target;
`endif

  predecode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .flush_i              (flush),
    .in_valid_i           (in_valid),
    .in_ready_o           (in_ready),
    .in_instr_i           (in_instr),
    .in_pc_i              (in_pc),
    .out_valid_o          (out_valid),
    .out_ready_i          (out_ready),
    .out_instr_o          (out_instr),
    .out_pc_o             (out_pc),
    .out_branch_jump_op_o (out_op),
    .out_imm_src_o        (out_imm),
    .out_illegal_o        (out_ill),
`ifdef PREDECODE_TARGET_EN
    .out_target_o         (out_target),
`endif
    .count_o              (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  op;
    logic [2:0]  imm;
    logic        ill;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  tbl[int];   // opcode -> {op, imm_src}
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  bit          m_push, m_pop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t make_ent(input logic [31:0] ins, input logic [31:0] p);
    ent_t e;
    int   off;
    e.instr = ins;
    e.pc    = p;
    e.op    = 2'b00;
    e.imm   = 3'b000;
    e.ill   = 1'b1;
    if (ins[1:0] == 2'b11 && tbl.exists(int'(ins[6:2]))) begin
      e.op  = tbl[int'(ins[6:2])][4:3];
      e.imm = tbl[int'(ins[6:2])][2:0];
      e.ill = 1'b0;
    end
    off = 4;
    if (!e.ill && ins[6:2] == 5'b11000)
      off = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    else if (!e.ill && ins[6:2] == 5'b11011)
      off = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e.tgt = p + off;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = out_ready && (q.size() > 0);
      if (m_pop)  q.delete(0);
      if (m_push) q.push_back(make_ent(in_instr, in_pc));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 64'(count), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("head_instr", 64'(out_instr), 64'(q[0].instr));
        check("head_pc", 64'(out_pc), 64'(q[0].pc));
        check("head_op", 64'(out_op), 64'(q[0].op));
        check("head_imm", 64'(out_imm), 64'(q[0].imm));
        check("head_illegal", 64'(out_ill), 64'(q[0].ill));
`ifdef PREDECODE_TARGET_EN
        check("head_target", 64'(out_target), 64'(q[0].tgt));
`endif
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p,
                      input bit rdy, input bit fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = p;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(0, 32'h0, 32'h0, 1, 0);
  endtask

  logic [31:0] pool[10];

  initial begin
    tbl[5'b00000] = {2'b00, 3'b100};
    tbl[5'b01000] = {2'b00, 3'b010};
    tbl[5'b01100] = {2'b00, 3'b000};
    tbl[5'b00100] = {2'b00, 3'b101};
    tbl[5'b11000] = {2'b10, 3'b011};
    tbl[5'b11011] = {2'b01, 3'b001};
    tbl[5'b11001] = {2'b01, 3'b100};
    tbl[5'b01101] = {2'b00, 3'b000};
    tbl[5'b00101] = {2'b00, 3'b000};
    tbl[5'b11100] = {2'b00, 3'b101};
    tbl[5'b01011] = {2'b00, 3'b000};
    pool = '{32'h00000013, 32'h0000006F, 32'hFE000EE3, 32'h00008067, 32'h00002083,
             32'h00112023, 32'h002081B3, 32'h000012B7, 32'h00000073, 32'h00000010};

    // reset
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(1, 32'h13, 32'h40, 1, 0);
    check("rst_count", 64'(count), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // addi at 0x100
    step(1, 32'h00000013, 32'h100, 0, 0);
    check("addi_valid", 64'(out_valid), 1);
    check("addi_op", 64'(out_op), 0);
    check("addi_imm", 64'(out_imm), 5);
    check("addi_illegal", 64'(out_ill), 0);
    check("addi_count", 64'(count), 1);
    check("addi_pc", 64'(out_pc), 64'h100);
    drain();

    // JAL then all-ones
    step(1, 32'h0000006F, 32'h104, 0, 0);
    step(1, 32'hFFFFFFFF, 32'h108, 0, 0);
    check("jal_op", 64'(out_op), 1);
    check("jal_imm", 64'(out_imm), 1);
    check("jal_illegal", 64'(out_ill), 0);
    step(0, 0, 0, 1, 0);
    check("ones_illegal", 64'(out_ill), 1);
    check("ones_op", 64'(out_op), 0);
    check("ones_imm", 64'(out_imm), 0);
    drain();

    // fill, reject fifth, drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 32'h00000013 | (i << 7), 32'h300 + 4 * i, 0, 0);
    check("full_in_ready", 64'(in_ready), 0);
    check("full_count", 64'(count), 4);
    step(1, 32'h00000033, 32'h3F0, 0, 0);
    check("fifth_count", 64'(count), 4);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 64'(out_pc), 64'(32'h300 + 4 * i));
      step(0, 0, 0, 1, 0);
    end
    check("drained_count", 64'(count), 0);

    // full, one pop, then simultaneous push+pop across wrap
    for (int i = 0; i < DEPTH; i++) step(1, 32'h00000003, 32'h400 + 4 * i, 0, 0);
    step(0, 0, 0, 1, 0);
    check("after_pop_count", 64'(count), 3);
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h00000023, 32'h500 + 4 * i, 1, 0);
      check("pushpop_count", 64'(count), 3);
    end
    check("wrap_head", 64'(out_pc), 64'h50C);
    drain();

    // flush with a concurrent push
    for (int i = 0; i < 3; i++) step(1, 32'h00000013, 32'h600 + 4 * i, 0, 0);
    check("preflush_count", 64'(count), 3);
    step(1, 32'h00000033, 32'h6F0, 1, 1);
    check("flush_count", 64'(count), 0);
    check("flush_valid", 64'(out_valid), 0);
    step(0, 0, 0, 0, 0);
    check("flush_dropped", 64'(count), 0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 32'h00000013, 32'h700 + 4 * i, 0, 0);
    rst_n = 1'b0;
    step(1, 32'h00000013, 32'h7F0, 1, 0);
    rst_n = 1'b1;
    check("midrst_count", 64'(count), 0);
    step(0, 0, 0, 1, 0);
    check("midrst_valid", 64'(out_valid), 0);

    // branch and jalr at 0x200
    step(1, 32'hFE000EE3, 32'h200, 0, 0);
    step(1, 32'h00008067, 32'h200, 0, 0);
    check("beq_op", 64'(out_op), 2);
    check("beq_imm", 64'(out_imm), 3);
`ifdef PREDECODE_TARGET_EN
    check("beq_target", 64'(out_target), 64'h1FC);
`endif
    step(0, 0, 0, 1, 0);
    check("jalr_op", 64'(out_op), 1);
    check("jalr_imm", 64'(out_imm), 4);
`ifdef PREDECODE_TARGET_EN
    check("jalr_target", 64'(out_target), 64'h204);
`endif
    drain();

    // mixed traffic, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, pool[$urandom_range(0, 9)],
           32'(i * 4 + 32'h1000), $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
